// File: rtl/code_loader.sv
// Byte-stream code loader: length byte, then big-endian 16-bit words written to code memory.
// Define CODE_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before completion.
module code_loader #(
  parameter int MAX_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        cm_we,
  output logic [5:0]  cm_addr,
  output logic [15:0] cm_data,
  output logic        cpu_halt,
  output logic        busy,
  output logic        done,
  output logic        error
);

`ifdef CODE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, DONE, ERR} state_t;
`endif

  localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

  state_t      state, nxt;
  logic [7:0]  len;
  logic [5:0]  idx;
  logic        we_q;
  logic        acc;
  logic        last;
  logic        idle_like;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign acc       = byte_valid & byte_ready;
  assign last      = ({2'b00, idx} == len - 8'd1);
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
  // Write strobe is gated by abort so a WRITE cycle that coincides with abort is dropped.
  assign cm_we     = we_q & ~abort;
  assign cm_addr   = idx;

  function automatic logic is_rx(input state_t s);
`ifdef CODE_LOADER_CHECKSUM_EN
    return (s == LEN) || (s == HI) || (s == LO) || (s == CHK);
`else
    return (s == LEN) || (s == HI) || (s == LO);
`endif
  endfunction

  function automatic logic is_busy(input state_t s);
    return is_rx(s) || (s == WRITE);
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start)              nxt = LEN;
        else if (state == DONE) nxt = IDLE;
      end
      LEN: begin
        if (abort)    nxt = ERR;
        else if (acc) nxt = (byte_in == 8'd0 || byte_in > MAX_LEN) ? ERR : HI;
      end
      HI: begin
        if (abort)    nxt = ERR;
        else if (acc) nxt = LO;
      end
      LO: begin
        if (abort)    nxt = ERR;
        else if (acc) nxt = WRITE;
      end
      WRITE: begin
        if (abort)     nxt = ERR;
        else if (!last) nxt = HI;
`ifdef CODE_LOADER_CHECKSUM_EN
        else           nxt = CHK;
`else
        else           nxt = DONE;
`endif
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      CHK: begin
        if (abort)    nxt = ERR;
        else if (acc) nxt = (byte_in == csum) ? DONE : ERR;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      we_q       <= 1'b0;
      cpu_halt   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      len        <= 8'd0;
      idx        <= 6'd0;
      cm_data    <= 16'd0;
`ifdef CODE_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      state      <= nxt;
      byte_ready <= is_rx(nxt);
      we_q       <= (nxt == WRITE);
      cpu_halt   <= is_busy(nxt);
      busy       <= is_busy(nxt);
      done       <= (nxt == DONE);
      error      <= (nxt == ERR);
      if (idle_like && start) begin
        idx <= 6'd0;
        len <= 8'd0;
`ifdef CODE_LOADER_CHECKSUM_EN
        csum <= 8'd0;
`endif
      end
      if (!abort) begin
        case (state)
          LEN: if (acc) len <= byte_in;
          HI: if (acc) begin
            cm_data[15:8] <= byte_in;
`ifdef CODE_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_in;
`endif
          end
          LO: if (acc) begin
            cm_data[7:0] <= byte_in;
`ifdef CODE_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_in;
`endif
          end
          // Index stops at the last word so a 64-word load never wraps the 6-bit address.
          WRITE: if (!last) idx <= idx + 6'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Randomized bench for code_loader: streams are scored against a queue-based reference model.
module tb_code_loader;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, cm_we, cpu_halt, busy, done, error;
  logic [5:0]  cm_addr;
  logic [15:0] cm_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  stim[$];
  logic [21:0] got_w[$];
  logic [21:0] exp_w[$];
  int          done_total = 0;
  bit          exp_err;
  int          n_use;

  code_loader #(.MAX_WORDS(64)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .cm_we(cm_we), .cm_addr(cm_addr), .cm_data(cm_data),
    .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (cm_we) got_w.push_back({cm_addr, cm_data});
    if (done)  done_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: length byte, then word i = {s[2i+1], s[2i+2]} at address i.
  task automatic model(input bit abort_last);
    int L;
    logic [7:0] x;
    exp_w.delete();
    L = int'(stim[0]);
    x = 8'd0;
    if (L == 0 || L > 64) begin
      exp_err = 1'b1;
      n_use   = 1;
      return;
    end
    for (int i = 0; i < L; i++) begin
      exp_w.push_back({6'(i), stim[1+2*i], stim[2+2*i]});
      x = x ^ stim[1+2*i] ^ stim[2+2*i];
    end
    n_use   = 1 + 2*L;
    exp_err = 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
    if (!abort_last) begin
      n_use++;
      exp_err = (stim[1+2*L] != x);
    end
`else
    if (x == 8'hxx) exp_err = 1'b1;
`endif
    if (abort_last) begin
      void'(exp_w.pop_back());
      exp_err = 1'b1;
    end
  endtask

  task automatic mk_stream(input int L);
    logic [7:0] x, b;
    stim.delete();
    stim.push_back(8'(L));
    x = 8'd0;
    for (int i = 0; i < 2*L; i++) begin
      b = 8'($urandom);
      stim.push_back(b);
      x = x ^ b;
    end
`ifdef CODE_LOADER_CHECKSUM_EN
    stim.push_back(x);
`endif
  endtask

  task automatic send(input logic [7:0] b, input bit jit, input bit ab, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      byte_in    = b;
      byte_valid = jit ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (byte_valid && byte_ready) begin
        abort = ab;
        ok    = 1'b1;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input bit jit, input bit abort_last);
    int w0, d0, nw;
    bit ok;
    w0 = got_w.size();
    d0 = done_total;
    model(abort_last);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < n_use; i++) begin
      send(stim[i], jit, abort_last && (i == n_use - 1), ok);
      if (!ok) begin
        check({tag, ".accept_timeout"}, 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clock); byte_valid = 1'b0; abort = 1'b0;
    for (int t = 0; t < 50 && busy; t++) @(negedge clock);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    check({tag, ".error"}, 32'(error), 32'(exp_err));
    check({tag, ".halt"}, 32'(cpu_halt), 32'd0);
    nw = got_w.size() - w0;
    check({tag, ".nwrites"}, 32'(nw), 32'(exp_w.size()));
    for (int i = 0; i < nw && i < exp_w.size(); i++)
      check($sformatf("%s.write%0d", tag, i), 32'(got_w[w0+i]), 32'(exp_w[i]));
    check({tag, ".done_pulses"}, 32'(done_total - d0), exp_err ? 32'd0 : 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int w0;
    #2;
    check("reset.outs", {byte_ready, cm_we, cpu_halt, busy, done, error, cm_addr, cm_data},
          32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle.outs", {byte_ready, cm_we, cpu_halt, busy, done, error}, 32'd0);

    stim = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef CODE_LOADER_CHECKSUM_EN
    stim.push_back(8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD);
`endif
    run("two_words", 1'b0, 1'b0);

    stim = '{8'h00};
    run("len00", 1'b0, 1'b0);
    stim = '{8'h41};
    run("len41", 1'b0, 1'b0);

`ifdef CODE_LOADER_CHECKSUM_EN
    stim = '{8'h01, 8'h12, 8'h34, 8'h26};
    run("csum_ok", 1'b0, 1'b0);
    stim = '{8'h01, 8'h12, 8'h34, 8'h27};
    run("csum_bad", 1'b0, 1'b0);
`endif

    mk_stream(64);
    run("full64", 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      mk_stream(int'($urandom_range(1, 10)));
      run($sformatf("rand%0d", k), bit'($urandom_range(0, 1)), 1'b0);
    end

    mk_stream(3);
    run("abort_last", 1'b0, 1'b1);

    // Reset while a word is half received.
    mk_stream(4);
    w0 = got_w.size();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    send(stim[0], 1'b0, 1'b0, ok);
    send(stim[1], 1'b0, 1'b0, ok);
    @(negedge clock); byte_valid = 1'b0;
    check("mid.busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid.reset_outs", {byte_ready, cm_we, cpu_halt, busy, done, error, cm_addr, cm_data},
          32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("mid.no_write", 32'(got_w.size() - w0), 32'd0);
    mk_stream(5);
    run("after_reset", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
